load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: LATENCY, default 2, cycles MemoryRead/MemoryWrite held per memory phase (legal 1..15).
REQ-002 Clock  input  1  system clock; all state updates on posedge Clock.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 ReqValid  input  1  request present from EX/MEM stage.
REQ-005 ReqReady  output  1  unit can accept a request this cycle.
REQ-006 ReqRead / ReqWrite  input  1 each  load / store request (exactly one set).
REQ-007 ReqSize  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-008 ReqSigned  input  1  sign-extend load result (ignored for double and stores).
REQ-009 ReqAddress  input  64  byte address.
REQ-010 ReqWriteData  input  64  store data, right-justified.
REQ-011 RespValid  output  1  one-cycle completion pulse.
REQ-012 RespData  output  64  load result (zero for stores and faults).
REQ-013 Fault  output  1  qualifies RespValid: request dropped.
REQ-014 Busy  output  1  high in any state other than IDLE; drives pipeline stall.
REQ-015 MemAddress  output  64  double-word index = ReqAddress >> 3, zero-extended.
REQ-016 MemWriteData  output  64  merged double-word to memory.
REQ-017 MemoryRead / MemoryWrite  output  1 each  memory strobes; never both high.
REQ-018 MemReadData  input  64  memory read data.

Function
REQ-019 FSM states IDLE, RD, MERGE, WR, RESP; ReqReady SHALL equal (state==IDLE).
REQ-020 Accept at cycle T when ReqValid&&ReqReady; address, size, signed, data, offset=ReqAddress[2:0] latched at T.
REQ-021 Load: RD for LATENCY cycles (T+1..T+LATENCY) with MemoryRead=1; MemReadData sampled in last RD cycle; RESP at T+LATENCY+1.
REQ-022 Load result: field of size bytes starting at byte offset (little-endian), zero- or sign-extended to 64 bits.
REQ-023 Double store: WR for LATENCY cycles with MemoryWrite=1, MemWriteData=latched data; RESP at T+LATENCY+1.
REQ-024 Partial store: RD (LATENCY cycles), MERGE (1 cycle, replace selected bytes), WR (LATENCY cycles); RESP at T+2*LATENCY+2.
REQ-025 RESP lasts exactly one cycle: RespValid=1, then IDLE; new request accepted earliest the cycle after RESP.
REQ-026 ReqRead==ReqWrite at acceptance: no strobes, RESP at T+1 with Fault=1, RespData=0.
REQ-027 MemAddress/MemWriteData held stable for every cycle a strobe is high; strobes low in IDLE, MERGE, RESP.
REQ-028 ReqValid while Busy SHALL be ignored (upstream holds request; no queueing).

Reset
REQ-029 Reset: state IDLE; ReqReady=1 on the following cycle; RespValid, Fault, Busy, MemoryRead, MemoryWrite=0; RespData, MemAddress, MemWriteData=0.
REQ-030 Reset mid-operation abandons the access: strobes low from the next cycle, no RespValid issued; contents of a word under write are undefined.
REQ-031 Reset has priority over an accept in the same cycle.

Configuration
REQ-032 Macro LSU_ALIGN_CHECK_EN defined: offset not a multiple of size bytes -> treated as REQ-026 fault (RESP at T+1, Fault=1, no strobes).
REQ-033 Macro undefined: offset low bits below size alignment forced to zero, access proceeds, Fault only for REQ-026 cases.

Verification
REQ-034 LATENCY=2; preload word 0x1 = 0x8877665544332211; load double addr 0x8 at T -> MemoryRead T+1..T+2, RespValid T+3, RespData 0x8877665544332211.
REQ-035 Same word; load byte signed addr 0xF -> RespData 0xFFFFFFFFFFFFFF88; unsigned -> 0x0000000000000088.
REQ-036 Store half 0xBEEF addr 0xA -> read T+1..T+2, MERGE T+3, write T+4..T+5, RespValid T+6; word 0x1 = 0x88776655BEEF2211.
REQ-037 ReqRead=ReqWrite=1 -> no strobes, RespValid+Fault at T+1; with LSU_ALIGN_CHECK_EN, load word addr 0xA -> same fault response.
REQ-038 Reset asserted at T+4 of REQ-036 store -> strobes low at T+5, no RespValid, ReqReady=1 at T+6; back-to-back requests during Busy ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word/double accesses onto a 64-bit double-word memory,
// with read-modify-write for partial stores. Define LSU_ALIGN_CHECK_EN to fault misaligned accesses.
module load_store_unit #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqRead,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [63:0] ReqAddress,
    input  logic [63:0] ReqWriteData,
    output logic        RespValid,
    output logic [63:0] RespData,
    output logic        Fault,
    output logic        Busy,
    output logic [63:0] MemAddress,
    output logic [63:0] MemWriteData,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    input  logic [63:0] MemReadData
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        read_q;
    logic [2:0]  offset_q;
    logic [63:0] data_q;
    logic [63:0] line_q;

    logic [2:0]  align_mask;
    logic [2:0]  offset_in;
    logic        bad_req;

    assign ReqReady = (state == IDLE);
    assign Busy     = (state != IDLE);

    always_comb begin
        align_mask = 3'b000;
        case (ReqSize)
            2'b00: align_mask = 3'b000;
            2'b01: align_mask = 3'b001;
            2'b10: align_mask = 3'b011;
            2'b11: align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    assign offset_in = ReqAddress[2:0];
    assign bad_req   = (ReqRead == ReqWrite) || ((ReqAddress[2:0] & align_mask) != 3'b000);
`else
    assign offset_in = ReqAddress[2:0] & ~align_mask;
    assign bad_req   = (ReqRead == ReqWrite);
`endif

    function automatic logic [63:0] extract(input logic [63:0] line, input logic [2:0] off,
                                            input logic [1:0] size, input logic sgn);
        logic [63:0] sh;
        sh = line >> {off, 3'b000};
        case (size)
            2'b00:   extract = sgn ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
            2'b01:   extract = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            2'b10:   extract = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
            default: extract = sh;
        endcase
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] line, input logic [63:0] data,
                                          input logic [2:0] off, input logic [1:0] size);
        logic [63:0] fmask;
        case (size)
            2'b00:   fmask = 64'h0000_0000_0000_00FF;
            2'b01:   fmask = 64'h0000_0000_0000_FFFF;
            2'b10:   fmask = 64'h0000_0000_FFFF_FFFF;
            default: fmask = '1;
        endcase
        fmask = fmask << {off, 3'b000};
        merge = (line & ~fmask) | ((data << {off, 3'b000}) & fmask);
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            count        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            read_q       <= 1'b0;
            offset_q     <= '0;
            data_q       <= '0;
            line_q       <= '0;
            RespValid    <= 1'b0;
            RespData     <= '0;
            Fault        <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            MemoryRead   <= 1'b0;
            MemoryWrite  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        size_q     <= ReqSize;
                        signed_q   <= ReqSigned;
                        read_q     <= ReqRead;
                        offset_q   <= offset_in;
                        data_q     <= ReqWriteData;
                        count      <= 4'(LATENCY - 1);
                        MemAddress <= {3'b000, ReqAddress[63:3]};
                        if (bad_req) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            Fault     <= 1'b1;
                        end else if (ReqRead || ReqSize != 2'b11) begin
                            // Loads and partial stores both start with a read of the whole double-word
                            state      <= RD;
                            MemoryRead <= 1'b1;
                        end else begin
                            state        <= WR;
                            MemoryWrite  <= 1'b1;
                            MemWriteData <= ReqWriteData;
                        end
                    end
                end
                RD: begin
                    if (count == 4'd0) begin
                        MemoryRead <= 1'b0;
                        if (read_q) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            RespData  <= extract(MemReadData, offset_q, size_q, signed_q);
                        end else begin
                            state  <= MERGE;
                            line_q <= MemReadData;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                MERGE: begin
                    state        <= WR;
                    MemWriteData <= merge(line_q, data_q, offset_q, size_q);
                    MemoryWrite  <= 1'b1;
                    count        <= 4'(LATENCY - 1);
                end
                WR: begin
                    if (count == 4'd0) begin
                        state       <= RESP;
                        MemoryWrite <= 1'b0;
                        RespValid   <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    RespValid <= 1'b0;
                    RespData  <= '0;
                    Fault     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (LATENCY=2) with a 16-entry double-word memory model.
module tb_load_store_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqRead;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [63:0] ReqAddress;
    logic [63:0] ReqWriteData;
    logic        RespValid;
    logic [63:0] RespData;
    logic        Fault;
    logic        Busy;
    logic [63:0] MemAddress;
    logic [63:0] MemWriteData;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [63:0] MemReadData;

    logic [63:0] mem [0:15];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [63:0] pre_data;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.LATENCY(2)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqRead(ReqRead), .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
        .ReqAddress(ReqAddress), .ReqWriteData(ReqWriteData), .RespValid(RespValid),
        .RespData(RespData), .Fault(Fault), .Busy(Busy), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .MemReadData(MemReadData)
    );

    always #5 Clock = ~Clock;

    assign MemReadData = mem[MemAddress[3:0]];

    always @(posedge Clock) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (MemoryWrite)
            mem[MemAddress[3:0]] <= MemWriteData;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Presents a request during cycle T; returns at cycle T+1.
    task automatic req(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [63:0] addr, input logic [63:0] wdata);
        ReqValid     = 1'b1;
        ReqRead      = rd;
        ReqWrite     = wr;
        ReqSize      = size;
        ReqSigned    = sgn;
        ReqAddress   = addr;
        ReqWriteData = wdata;
        step();
        ReqValid = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [1:0] size, input logic sgn,
                              input logic [63:0] addr, input logic [63:0] exp);
        req(1'b1, 1'b0, size, sgn, addr, 64'd0);
        step();
        step();
        chk({tag, "_valid"}, {63'd0, RespValid}, 64'd1);
        chk({tag, "_data"}, RespData, exp);
        step();
    endtask

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; ReqRead = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
        ReqSigned = 1'b0; ReqAddress = '0; ReqWriteData = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        #1;
        for (int i = 0; i < 16; i++) begin
            pre_we   = 1'b1;
            pre_addr = 4'(i);
            pre_data = (i == 1) ? 64'h8877_6655_4433_2211 : 64'd0;
            step();
        end
        pre_we = 1'b0;
        step();

        chk("rst_respvalid", {63'd0, RespValid}, 64'd0);
        chk("rst_fault", {63'd0, Fault}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_memread", {63'd0, MemoryRead}, 64'd0);
        chk("rst_memwrite", {63'd0, MemoryWrite}, 64'd0);
        chk("rst_respdata", RespData, 64'd0);
        chk("rst_memaddr", MemAddress, 64'd0);
        chk("rst_memwdata", MemWriteData, 64'd0);
        Reset = 1'b0;
        step();
        chk("rst_ready", {63'd0, ReqReady}, 64'd1);

        // Double load at 0x8, with a store presented while busy that must be dropped
        req(1'b1, 1'b0, 2'b11, 1'b0, 64'h8, 64'd0);
        chk("ld64_rd_t1", {63'd0, MemoryRead}, 64'd1);
        chk("ld64_wr_t1", {63'd0, MemoryWrite}, 64'd0);
        chk("ld64_addr_t1", MemAddress, 64'd1);
        chk("ld64_busy_t1", {63'd0, Busy}, 64'd1);
        chk("ld64_ready_t1", {63'd0, ReqReady}, 64'd0);
        ReqValid = 1'b1; ReqRead = 1'b0; ReqWrite = 1'b1; ReqSize = 2'b11;
        ReqAddress = 64'h0; ReqWriteData = 64'hDEAD;
        step();
        chk("ld64_rd_t2", {63'd0, MemoryRead}, 64'd1);
        chk("ld64_addr_t2", MemAddress, 64'd1);
        chk("ld64_valid_t2", {63'd0, RespValid}, 64'd0);
        step();
        ReqValid = 1'b0;
        chk("ld64_valid_t3", {63'd0, RespValid}, 64'd1);
        chk("ld64_fault_t3", {63'd0, Fault}, 64'd0);
        chk("ld64_data_t3", RespData, 64'h8877_6655_4433_2211);
        chk("ld64_rd_t3", {63'd0, MemoryRead}, 64'd0);
        step();
        chk("ld64_valid_t4", {63'd0, RespValid}, 64'd0);
        chk("ld64_ready_t4", {63'd0, ReqReady}, 64'd1);
        chk("ignored_busy", {63'd0, Busy}, 64'd0);
        chk("ignored_mem0", mem[0], 64'd0);

        load_check("ldb_s", 2'b00, 1'b1, 64'hF, 64'hFFFF_FFFF_FFFF_FF88);
        load_check("ldb_u", 2'b00, 1'b0, 64'hF, 64'h0000_0000_0000_0088);
        load_check("ldw_s", 2'b10, 1'b1, 64'hC, 64'hFFFF_FFFF_8877_6655);
        load_check("ldh_u", 2'b01, 1'b0, 64'hA, 64'h0000_0000_0000_4433);

        // Partial store: read, merge, write
        req(1'b0, 1'b1, 2'b01, 1'b0, 64'hA, 64'hBEEF);
        chk("sth_rd_t1", {63'd0, MemoryRead}, 64'd1);
        chk("sth_wr_t1", {63'd0, MemoryWrite}, 64'd0);
        step();
        chk("sth_rd_t2", {63'd0, MemoryRead}, 64'd1);
        step();
        chk("sth_rd_t3", {63'd0, MemoryRead}, 64'd0);
        chk("sth_wr_t3", {63'd0, MemoryWrite}, 64'd0);
        chk("sth_busy_t3", {63'd0, Busy}, 64'd1);
        step();
        chk("sth_wr_t4", {63'd0, MemoryWrite}, 64'd1);
        chk("sth_wdata_t4", MemWriteData, 64'h8877_6655_BEEF_2211);
        chk("sth_addr_t4", MemAddress, 64'd1);
        step();
        chk("sth_wr_t5", {63'd0, MemoryWrite}, 64'd1);
        chk("sth_wdata_t5", MemWriteData, 64'h8877_6655_BEEF_2211);
        step();
        chk("sth_valid_t6", {63'd0, RespValid}, 64'd1);
        chk("sth_respdata_t6", RespData, 64'd0);
        chk("sth_wr_t6", {63'd0, MemoryWrite}, 64'd0);
        step();
        chk("sth_mem1", mem[1], 64'h8877_6655_BEEF_2211);
        load_check("ld64_after_sth", 2'b11, 1'b0, 64'h8, 64'h8877_6655_BEEF_2211);

        // Double store needs no read phase
        req(1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h0123_4567_89AB_CDEF);
        chk("std_wr_t1", {63'd0, MemoryWrite}, 64'd1);
        chk("std_rd_t1", {63'd0, MemoryRead}, 64'd0);
        chk("std_wdata_t1", MemWriteData, 64'h0123_4567_89AB_CDEF);
        chk("std_addr_t1", MemAddress, 64'd2);
        step();
        chk("std_wr_t2", {63'd0, MemoryWrite}, 64'd1);
        step();
        chk("std_valid_t3", {63'd0, RespValid}, 64'd1);
        chk("std_wr_t3", {63'd0, MemoryWrite}, 64'd0);
        step();
        chk("std_mem2", mem[2], 64'h0123_4567_89AB_CDEF);

        // Both read and write set: immediate fault
        req(1'b1, 1'b1, 2'b10, 1'b0, 64'h8, 64'd0);
        chk("flt_valid_t1", {63'd0, RespValid}, 64'd1);
        chk("flt_fault_t1", {63'd0, Fault}, 64'd1);
        chk("flt_data_t1", RespData, 64'd0);
        chk("flt_rd_t1", {63'd0, MemoryRead}, 64'd0);
        chk("flt_wr_t1", {63'd0, MemoryWrite}, 64'd0);
        step();
        chk("flt_valid_t2", {63'd0, RespValid}, 64'd0);
        chk("flt_fault_t2", {63'd0, Fault}, 64'd0);
        chk("flt_ready_t2", {63'd0, ReqReady}, 64'd1);

`ifdef LSU_ALIGN_CHECK_EN
        req(1'b1, 1'b0, 2'b10, 1'b0, 64'hA, 64'd0);
        chk("mis_valid_t1", {63'd0, RespValid}, 64'd1);
        chk("mis_fault_t1", {63'd0, Fault}, 64'd1);
        chk("mis_rd_t1", {63'd0, MemoryRead}, 64'd0);
        step();
`else
        load_check("mis_ldw_u", 2'b10, 1'b0, 64'hA, 64'h0000_0000_BEEF_2211);
`endif

        // Reset during the first write cycle of a partial store
        req(1'b0, 1'b1, 2'b01, 1'b0, 64'hA, 64'h1234);
        step();
        step();
        step();
        chk("rstmid_wr_t4", {63'd0, MemoryWrite}, 64'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rstmid_wr_t5", {63'd0, MemoryWrite}, 64'd0);
        chk("rstmid_rd_t5", {63'd0, MemoryRead}, 64'd0);
        chk("rstmid_valid_t5", {63'd0, RespValid}, 64'd0);
        step();
        chk("rstmid_ready_t6", {63'd0, ReqReady}, 64'd1);
        chk("rstmid_valid_t6", {63'd0, RespValid}, 64'd0);
        chk("rstmid_busy_t6", {63'd0, Busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
